sort_stream_feeder: RTL and testbench

Transmit-side companion to the quicksort shell. Buffers K signed fixed-point words written by a host, then on a `go` request drives the sorter's input protocol. That protocol is a one-cycle `start` pulse followed by K consecutive words on `inp_raw`, one per clock. The block sits between the host/register interface and the sorter's `start`/`inp_raw` ports.

---
 rtl/sort_pkg.sv | 17 +
 rtl/float_to_qfixed.sv | 34 +++
 rtl/sort_stream_feeder.sv | 112 +++++++++++
 tb/tb_sort_stream_feeder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared defaults, FSM encoding and Q-format saturation constants for the sort feeder.
package sort_pkg;
  localparam int SORT_N = 23;
  localparam int SORT_M = 8;
  localparam int SORT_L = SORT_N + SORT_M + 1;
  localparam int SORT_K = 10;
  localparam int SORT_S = $clog2(SORT_K) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam logic [31:0] Q_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] Q_MIN = 32'h8000_0000;
endpackage

// File: rtl/float_to_qfixed.sv
// IEEE-754 single to signed Q(M).(N) in a 32-bit word: truncates toward zero, saturates on overflow/Inf/NaN.
module float_to_qfixed
  import sort_pkg::*;
#(
  parameter int N = SORT_N,
  parameter int M = SORT_M
) (
  input  logic [31:0] f,
  output logic [31:0] q
);
  logic [31:0] mag;
  int          e;
  int          sh;

  always_comb begin
    e   = int'({24'd0, f[30:23]}) - 127;
    // mantissa LSB already weighs 2^-23, so re-align to the 2^-N grid
    sh  = e + N - 23;
    mag = '0;
    if (sh >= 0)
      mag = {8'd0, 1'b1, f[22:0]} << sh[4:0];
    else if (sh > -32)
      mag = {8'd0, 1'b1, f[22:0]} >> 5'(-sh);

    if (f[30:23] == 8'd0)
      q = '0;
    else if (f[30:23] == 8'hFF)
      q = (f[31] && f[22:0] == 23'd0) ? Q_MIN : Q_MAX;
    else if (e >= M)
      q = f[31] ? Q_MIN : Q_MAX;
    else
      q = f[31] ? -mag : mag;
  end
endmodule

// File: rtl/sort_stream_feeder.sv
// Buffers K host words and replays them to the sorter as start pulse + K-word burst.
// Define FLOAT_IN_EN to accept IEEE-754 singles on wr_data and store them as Q(M).(N).
module sort_stream_feeder
  import sort_pkg::*;
#(
  parameter int N = SORT_N,
  parameter int M = SORT_M,
  parameter int L = N + M + 1,
  parameter int K = SORT_K,
  parameter int S = $clog2(K) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [S-1:0] wr_addr,
  input  logic [L-1:0] wr_data,
  input  logic         go,
  output logic         start,
  output logic [L-1:0] inp_raw,
  output logic [S-1:0] word_idx,
  output logic         busy,
  output logic         done,
  output logic         wr_err
);
  localparam int           AW    = (K > 1) ? $clog2(K) : 1;
  localparam logic [S-1:0] KS    = S'(K);
  localparam logic [S-1:0] KLAST = S'(K - 1);

  state_t         state, state_nx;
  logic [L-1:0]   mem [K];
  logic [L-1:0]   wval;
  logic           wr_ok;
  logic           start_nx, busy_nx, done_nx;
  logic [L-1:0]   inp_nx;
  logic [S-1:0]   idx_nx;

`ifdef FLOAT_IN_EN
  float_to_qfixed #(.N(N), .M(M)) u_cvt (
    .f (wr_data),
    .q (wval)
  );
`else
  assign wval = wr_data;
`endif

  // the done cycle is IDLE, so writes and a fresh go are both legal there
  assign wr_ok = wr_en && (state == IDLE) && (wr_addr < KS);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (go) state_nx = START;
      START:   state_nx = STREAM;
      STREAM:  if (word_idx == KLAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // word_idx doubles as the stream counter; outputs are the registered copy of these
  always_comb begin
    start_nx = 1'b0;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    inp_nx   = '0;
    idx_nx   = '0;
    case (state)
      IDLE: if (go) begin
        start_nx = 1'b1;
        busy_nx  = 1'b1;
      end
      START: begin
        busy_nx = 1'b1;
        inp_nx  = mem[0];
      end
      STREAM: begin
        if (word_idx == KLAST) begin
          done_nx = 1'b1;
        end else begin
          busy_nx = 1'b1;
          idx_nx  = word_idx + S'(1);
          inp_nx  = mem[idx_nx[AW-1:0]];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      inp_raw  <= '0;
      word_idx <= '0;
      wr_err   <= 1'b0;
      for (int i = 0; i < K; i++) mem[i] <= '0;
    end else begin
      start    <= start_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      inp_raw  <= inp_nx;
      word_idx <= idx_nx;
      wr_err   <= wr_en && !wr_ok;
      if (wr_ok) mem[wr_addr[AW-1:0]] <= wval;
    end
  end
endmodule

// File: tb/tb_sort_stream_feeder.sv
// Directed bench for sort_stream_feeder: cycle-phase model compared every cycle plus literal batch checks.
module tb_sort_stream_feeder;
  import sort_pkg::*;
  localparam int K = SORT_K;
  localparam int L = SORT_L;
  localparam int S = SORT_S;

  logic         clk, reset, wr_en, go;
  logic [S-1:0] wr_addr;
  logic [L-1:0] wr_data;
  logic         start, busy, done, wr_err;
  logic [L-1:0] inp_raw;
  logic [S-1:0] word_idx;

  int vectors = 0;
  int errs    = 0;
  bit armed   = 0;

  logic [31:0] cur_tbl [K];
  logic [31:0] norm_tbl [K];

  sort_stream_feeder dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .go       (go),
    .start    (start),
    .inp_raw  (inp_raw),
    .word_idx (word_idx),
    .busy     (busy),
    .done     (done),
    .wr_err   (wr_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] f2q(input logic [31:0] f);
    real r;
    int  ex;
    ex = int'(f[30:23]);
    if (ex == 0) return 32'h0;
    if (ex == 255) return (f[31] && f[22:0] == 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    r = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (ex - 127));
    if (r >= 256.0) return f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return f[31] ? -$rtoi(r * 8388608.0) : $rtoi(r * 8388608.0);
  endfunction

  // model: ph counts cycles since an accepted go; 1=start, 2..K+1=words, K+2=done
  int          ph = 0;
  logic [31:0] mem_m [K];
  logic        e_err = 0;
  wire m_idle = (ph == 0) || (ph == K + 2);
  wire m_ok   = wr_en && m_idle && (int'(wr_addr) < K);

  always @(posedge clk) begin
    if (reset) begin
      ph    <= 0;
      e_err <= 0;
      for (int i = 0; i < K; i++) mem_m[i] <= 0;
    end else begin
      e_err <= wr_en && !m_ok;
`ifdef FLOAT_IN_EN
      if (m_ok) mem_m[int'(wr_addr)] <= f2q(wr_data);
`else
      if (m_ok) mem_m[int'(wr_addr)] <= wr_data;
`endif
      if (m_idle && go) ph <= 1;
      else if (ph == K + 2) ph <= 0;
      else if (ph != 0) ph <= ph + 1;
    end
  end

  function automatic logic [31:0] m_inp();
    return (ph >= 2 && ph <= K + 1) ? mem_m[ph-2] : 32'h0;
  endfunction
  function automatic logic [31:0] m_idx();
    return (ph >= 2 && ph <= K + 1) ? 32'(ph - 2) : 32'h0;
  endfunction

  always @(negedge clk) begin
    if (armed) begin
      chk("m_start", 32'(start), 32'(ph == 1));
      chk("m_busy",  32'(busy),  32'(ph >= 1 && ph <= K + 1));
      chk("m_done",  32'(done),  32'(ph == K + 2));
      chk("m_inp",   32'(inp_raw), m_inp());
      chk("m_idx",   32'(word_idx), m_idx());
      chk("m_err",   32'(wr_err), 32'(e_err));
    end
  end

  // issue go, then check the burst against cur_tbl; optional busy-time write/go injection
  task automatic run_batch(input int inj_wr, input int inj_go);
    go = 1;
    @(posedge clk); #1;
    go = 0; wr_en = 0;
    @(negedge clk);
    chk("start", 32'(start), 32'd1);
    chk("start_inp", inp_raw, 32'h0);
    for (int i = 0; i < K; i++) begin
      @(negedge clk);
      chk("word", inp_raw, cur_tbl[i]);
      chk("word_idx", 32'(word_idx), 32'(i));
      if (inj_go >= 0 && i == inj_go) go = 1;
      if (inj_go >= 0 && i == inj_go + 2) go = 0;
      if (inj_wr >= 0 && i == inj_wr + 1) begin
        chk("busy_wr_err", 32'(wr_err), 32'd1);
        wr_en = 0;
      end
      if (inj_wr >= 0 && i == inj_wr) begin
        wr_en = 1; wr_addr = 3; wr_data = 32'h1234_5678;
      end
    end
    @(negedge clk);
    chk("done", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_inp", inp_raw, 32'h0);
  endtask

  task automatic load(input logic [31:0] t [K]);
    for (int i = 0; i < K; i++) begin
      wr_en = 1; wr_addr = S'(i); wr_data = t[i];
      @(negedge clk);
    end
    wr_en = 0;
  endtask

  initial begin
    norm_tbl = '{32'h0340_0000, 32'hACCC_CCD0, 32'hF57E_80C8, 32'hF600_0000, 32'h0000_0000,
                 32'h0000_0000, 32'h0600_0000, 32'hFF80_0000, 32'h0680_0000, 32'hFB00_0000};
    reset = 1; go = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    @(posedge clk); #1 armed = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_start", 32'(start), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_inp",   inp_raw, 0);
    reset = 0;
    @(negedge clk);
    for (int i = 0; i < K; i++) cur_tbl[i] = 0;
    run_batch(-1, -1);
    @(negedge clk);

`ifdef FLOAT_IN_EN
    begin
      logic [31:0] fin [K];
      fin = '{32'h40D0_0000, 32'hC2A0_0000, 32'h4380_0000, 32'hC400_0000, 32'h7FC0_0000,
              32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
      cur_tbl = '{32'h0340_0000, 32'hD800_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                  32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      load(fin);
      run_batch(-1, -1);
    end
`else
    load(norm_tbl);
    cur_tbl = norm_tbl;
    run_batch(5, 2);
    run_batch(-1, -1);
    @(negedge clk);
    @(negedge clk);
    wr_en = 1; wr_addr = S'(K); wr_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("addr_wr_err", 32'(wr_err), 32'd1);
    wr_en = 0;
    @(negedge clk);
    run_batch(-1, -1);
    @(negedge clk);
    cur_tbl[4] = 32'h1111_1111;
    wr_en = 1; wr_addr = 4; wr_data = 32'h1111_1111;
    run_batch(-1, -1);
    @(negedge clk);
    go = 1;
    @(posedge clk); #1 go = 0;
    repeat (6) @(negedge clk);
    chk("mid_word4", inp_raw, 32'h0000_0000 | cur_tbl[4]);
    reset = 1;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_inp",  inp_raw, 0);
    chk("mid_done", 32'(done), 0);
    reset = 0;
    for (int i = 0; i < K + 2; i++) begin
      @(negedge clk);
      chk("mid_nodone", 32'(done), 0);
    end
    for (int i = 0; i < K; i++) cur_tbl[i] = 0;
    run_batch(-1, -1);
`endif
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
